fwd_hazard_unit: RTL and testbench

- Parametrised successor to the fixed 5-stage forwarding mux-select logic.
- Tracks in-flight producers in a Tnew-based tag pipeline covering the NSTAGE post-decode stages (stage 1 = E, 2 = M, 3 = W for the default).
- Generates D-stage and E-stage forward selects for NSRC source operands, the decode stall/bubble, and mult/div busy interlocking.
- Sits beside the datapath; the datapath consumes the selects and the stall.

---
 rtl/fwd_hazard_unit_pkg.sv | 11 +
 rtl/fwd_tag_pipe.sv | 60 ++++++
 rtl/fwd_hazard_unit.sv | 130 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings and default latencies for the forwarding/hazard unit and decode.
// Forward selects are 0 for the register file, or k for the result at post-decode stage k.
package fwd_hazard_unit_pkg;
    localparam int FWD_RF       = 0;
    localparam int DEF_TW       = 2;
    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    typedef logic [DEF_TW-1:0] tval_t;
endpackage

// File: rtl/fwd_tag_pipe.sv
// In-flight producer tags, one entry per post-decode stage (entry 1 = E).
// Tnew counts down as the entry ages and saturates at 0 once the result is forwardable.
module fwd_tag_pipe
    import fwd_hazard_unit_pkg::*;
#(
    parameter int AW     = 5,
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int TW     = DEF_TW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bubble_i,
    input  logic                    flush_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [TW-1:0]           tnew_i,
    output logic [NSTAGE:1]         vld_o,
    output logic [NSTAGE:1][AW-1:0] addr_o,
    output logic [NSTAGE:1][TW-1:0] tnew_o
);
    logic [NSTAGE:1]         vld_q, vld_d;
    logic [NSTAGE:1][AW-1:0] addr_q, addr_d;
    logic [NSTAGE:1][TW-1:0] tnew_q, tnew_d;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        tnew_d = tnew_q;
        if (flush_i || bubble_i) begin
            vld_d[1]  = 1'b0;
            addr_d[1] = '0;
            tnew_d[1] = '0;
        end else begin
            vld_d[1]  = we_i;
            addr_d[1] = addr_i;
            tnew_d[1] = tnew_i;
        end
        for (int k = 2; k <= NSTAGE; k++) begin
            vld_d[k]  = vld_q[k-1];
            addr_d[k] = addr_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            addr_q <= '0;
            tnew_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            tnew_q <= tnew_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;
    assign tnew_o = tnew_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forward-select, decode stall and mult/div interlock generation beside the datapath.
// Selects and stall are combinational from D inputs and registered tags; md_busy is registered.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int   AW       = 5,
    parameter int   NSRC     = 2,
    parameter int   NSTAGE   = DEF_NSTAGE,
    parameter int   TW       = DEF_TW,
    parameter int   MULT_LAT = DEF_MULT_LAT,
    parameter int   DIV_LAT  = DEF_DIV_LAT,
    localparam int  SW       = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   src_addr_d,
    input  logic [NSRC-1:0]      src_use_d,
    input  logic [NSRC*TW-1:0]   tuse_d,
    input  logic                 dst_we_d,
    input  logic [AW-1:0]        dst_addr_d,
    input  logic [TW-1:0]        tnew_d,
    input  logic                 md_start_d,
    input  logic                 md_div_d,
    input  logic                 md_use_d,
    input  logic                 flush_e,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel_d,
    output logic [NSRC*SW-1:0]   fwd_sel_e,
    output logic                 md_busy
);
    localparam int MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic [NSTAGE:1]         tag_vld;
    logic [NSTAGE:1][AW-1:0] tag_addr;
    logic [NSTAGE:1][TW-1:0] tag_tnew;

    logic                data_hz, md_hz, adv, e_illegal;
    logic [NSRC-1:0]     src_use_e_q;
    logic [NSRC*AW-1:0]  src_addr_e_q;
    logic                md_start_e_q, md_div_e_q;
    logic [CW-1:0]       md_cnt_q, md_cnt_d;

    fwd_tag_pipe #(.AW(AW), .NSTAGE(NSTAGE), .TW(TW)) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (stall),
        .flush_i  (flush_e),
        .we_i     (dst_we_d && (dst_addr_d != '0)),
        .addr_i   (dst_addr_d),
        .tnew_i   (tnew_d),
        .vld_o    (tag_vld),
        .addr_o   (tag_addr),
        .tnew_o   (tag_tnew)
    );

    // Stages are scanned oldest to youngest so the youngest match is the one left standing.
    always_comb begin : d_match
        logic [SW-1:0] sel;
        logic          hz;
        fwd_sel_d = '0;
        data_hz   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            sel = SW'(FWD_RF);
            hz  = 1'b0;
            for (int k = NSTAGE; k >= 1; k--) begin
                if (tag_vld[k] && (tag_addr[k] == src_addr_d[i*AW +: AW]) &&
                    (src_addr_d[i*AW +: AW] != '0)) begin
                    sel = (tag_tnew[k] == '0) ? SW'(k) : SW'(FWD_RF);
                    hz  = src_use_d[i] && (tag_tnew[k] > tuse_d[i*TW +: TW]);
                end
            end
            fwd_sel_d[i*SW +: SW] = sel;
            data_hz = data_hz | hz;
        end
    end

    // Stage 1 is the E instruction itself, so E operands only look at stage 2 onward.
    always_comb begin : e_match
        logic [SW-1:0] sel;
        logic          ill;
        fwd_sel_e = '0;
        e_illegal = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            sel = SW'(FWD_RF);
            ill = 1'b0;
            for (int k = NSTAGE; k >= 2; k--) begin
                if (src_use_e_q[i] && tag_vld[k] && (tag_addr[k] == src_addr_e_q[i*AW +: AW]) &&
                    (src_addr_e_q[i*AW +: AW] != '0)) begin
                    sel = (tag_tnew[k] == '0) ? SW'(k) : SW'(FWD_RF);
                    ill = (tag_tnew[k] != '0);
                end
            end
            fwd_sel_e[i*SW +: SW] = sel;
            e_illegal = e_illegal | ill;
        end
    end

    assign md_busy = (md_cnt_q != '0);
    assign md_hz   = md_use_d && (md_busy || md_start_e_q);
    assign stall   = data_hz || md_hz;
    assign adv     = !stall && !flush_e;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_e_q) begin
            md_cnt_d = md_div_e_q ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_use_e_q  <= '0;
            src_addr_e_q <= '0;
            md_start_e_q <= 1'b0;
            md_div_e_q   <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            src_use_e_q  <= adv ? src_use_d : '0;
            src_addr_e_q <= adv ? src_addr_d : '0;
            md_start_e_q <= adv && md_start_d;
            md_div_e_q   <= adv && md_div_d;
            md_cnt_q     <= md_cnt_d;
        end
    end

    a_e_fwd_ready: assert property (@(posedge clk) disable iff (reset) !e_illegal);
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios plus random traffic against a
// producer-list model that tracks each writer by the absolute cycle it entered E.
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    localparam int AW = 5, NSRC = 2, NSTAGE = 3, TW = 2, SW = 2;
    localparam int MULT_LAT = 5, DIV_LAT = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic [NSRC*AW-1:0]  src_addr_d;
    logic [NSRC-1:0]     src_use_d;
    logic [NSRC*TW-1:0]  tuse_d;
    logic                dst_we_d;
    logic [AW-1:0]       dst_addr_d;
    tval_t               tnew_d;
    logic                md_start_d, md_div_d, md_use_d, flush_e;
    logic                stall, md_busy;
    logic [NSRC*SW-1:0]  fwd_sel_d, fwd_sel_e;

    fwd_hazard_unit #(
        .AW(AW), .NSRC(NSRC), .NSTAGE(NSTAGE), .TW(TW),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .src_addr_d(src_addr_d), .src_use_d(src_use_d), .tuse_d(tuse_d),
        .dst_we_d(dst_we_d), .dst_addr_d(dst_addr_d), .tnew_d(tnew_d),
        .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .flush_e(flush_e),
        .stall(stall), .fwd_sel_d(fwd_sel_d), .fwd_sel_e(fwd_sel_e), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_cyc;
        int addr;
        int tnew;
    } prod_t;

    prod_t              prods[$];
    int                 cyc = 0;
    int                 md_e_cyc = -100;
    int                 md_lat = 0;
    int                 e_use [NSRC];
    int                 e_addr[NSRC];
    logic               exp_stall, exp_busy;
    logic [NSRC*SW-1:0] exp_sel_d, exp_sel_e;
    int                 n_cmp = 0;
    int                 n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Youngest in-flight writer of a at stage >= kmin, and its remaining Tnew there.
    function automatic void youngest(input int a, input int kmin, output int stage, output int tn);
        int st;
        stage = 0;
        tn    = 0;
        if (a == 0) return;
        foreach (prods[j]) begin
            st = cyc - prods[j].e_cyc + 1;
            if (prods[j].addr == a && st >= kmin && st <= NSTAGE && (stage == 0 || st < stage)) begin
                stage = st;
                tn    = (prods[j].tnew > st - 1) ? prods[j].tnew - (st - 1) : 0;
            end
        end
    endfunction

    task automatic model_reset();
        prods.delete();
        md_e_cyc = -100;
        md_lat   = 0;
        for (int i = 0; i < NSRC; i++) begin
            e_use[i]  = 0;
            e_addr[i] = 0;
        end
    endtask

    task automatic model_eval();
        int st, tn;
        exp_stall = 1'b0;
        exp_sel_d = '0;
        exp_sel_e = '0;
        for (int i = 0; i < NSRC; i++) begin
            youngest(int'(src_addr_d[i*AW +: AW]), 1, st, tn);
            if (st != 0 && tn == 0) exp_sel_d[i*SW +: SW] = SW'(st);
            if (st != 0 && src_use_d[i] && tn > int'(tuse_d[i*TW +: TW])) exp_stall = 1'b1;
            if (e_use[i] != 0) begin
                youngest(e_addr[i], 2, st, tn);
                if (st != 0 && tn == 0) exp_sel_e[i*SW +: SW] = SW'(st);
            end
        end
        exp_busy = (cyc > md_e_cyc) && (cyc <= md_e_cyc + md_lat);
        if (md_use_d && (exp_busy || cyc == md_e_cyc)) exp_stall = 1'b1;
    endtask

    task automatic settle_check();
        #1;
        model_eval();
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("md_busy", 32'(md_busy), 32'(exp_busy));
        chk("fwd_sel_d", 32'(fwd_sel_d), 32'(exp_sel_d));
        chk("fwd_sel_e", 32'(fwd_sel_e), 32'(exp_sel_e));
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (!exp_stall && !flush_e) begin
                if (dst_we_d && dst_addr_d != '0)
                    prods.push_back('{cyc, int'(dst_addr_d), int'(tnew_d)});
                for (int i = 0; i < NSRC; i++) begin
                    e_use[i]  = int'(src_use_d[i]);
                    e_addr[i] = int'(src_addr_d[i*AW +: AW]);
                end
                if (md_start_d) begin
                    md_e_cyc = cyc;
                    md_lat   = md_div_d ? DIV_LAT : MULT_LAT;
                end
            end else begin
                for (int i = 0; i < NSRC; i++) e_use[i] = 0;
            end
            while (prods.size() > 0 && cyc - prods[0].e_cyc + 1 > NSTAGE) void'(prods.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drive(input int s0, input bit u0, input int t0,
                         input int s1, input bit u1, input int t1,
                         input bit we, input int dst, input int tn,
                         input bit ms, input bit mdv, input bit mu, input bit fl);
        src_addr_d = {AW'(s1), AW'(s0)};
        src_use_d  = {u1, u0};
        tuse_d     = {TW'(t1), TW'(t0)};
        dst_we_d   = we;
        dst_addr_d = AW'(dst);
        tnew_d     = TW'(tn);
        md_start_d = ms;
        md_div_d   = mdv;
        md_use_d   = mu;
        flush_e    = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) begin
            nop();
            settle_check();
            advance();
        end
    endtask

    task automatic md_run(input bit is_div, input int lat, input string tag);
        int nbusy, nst;
        bit done;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, is_div, 1, 0);
        settle_check();
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        nbusy = 0;
        nst   = 0;
        done  = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            settle_check();
            if (md_busy) nbusy++;
            if (!stall) done = 1;
            else begin
                nst++;
                advance();
            end
        end
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(lat));
        chk({tag, "_stall_cycles"}, 32'(nst), 32'(lat + 1));
        advance();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        nop();
        model_reset();
        @(negedge clk);
        settle_check();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_busy", 32'(md_busy), 0);
        advance();
        reset = 1'b0;
        drain(2);

        // addu $3 (tnew 1) followed by beq $3 (tuse 0)
        drive(0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);
        settle_check(); advance();
        drive(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle_check(); chk("t1_stall_on", 32'(stall), 1); advance();
        settle_check(); chk("t1_stall_off", 32'(stall), 0);
        chk("t1_sel_m", 32'(fwd_sel_d[SW-1:0]), 2); advance();
        settle_check(); chk("t1_next_nostall", 32'(stall), 0); advance();
        drain(4);

        // lw $5 (tnew 2) followed by addu $5 (tuse 1)
        drive(0, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0);
        settle_check(); advance();
        drive(5, 1, 1, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0);
        settle_check(); chk("t2_stall_on", 32'(stall), 1); advance();
        settle_check(); chk("t2_stall_off", 32'(stall), 0); advance();
        nop();
        settle_check(); chk("t2_sel_e_w", 32'(fwd_sel_e[SW-1:0]), 3); advance();
        drain(4);

        // two writers of $7 in flight; second operand reads $0 while $0 is written
        drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        settle_check(); advance();
        settle_check(); advance();
        drive(7, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        settle_check(); chk("t3_sel_youngest", 32'(fwd_sel_d), 1);
        chk("t3_stall", 32'(stall), 0); advance();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle_check(); chk("t3_r0_sel", 32'(fwd_sel_d), 0);
        chk("t3_r0_stall", 32'(stall), 0); advance();
        drain(4);

        md_run(1'b0, MULT_LAT, "mult");
        drain(2);
        md_run(1'b1, DIV_LAT, "div");
        drain(2);

        // flush squashes lw $4 on its way into E
        drive(0, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0, 1);
        settle_check(); advance();
        drive(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle_check(); chk("t5_stall", 32'(stall), 0);
        chk("t5_sel", 32'(fwd_sel_d), 0); advance();
        drain(4);

        // reset with lw $9 at M and the divide counter at 6
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        settle_check(); advance();
        drain(3);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0);
        settle_check(); advance();
        drain(1);
        drive(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle_check();
        chk("t6_pre_sel", 32'(fwd_sel_d[SW-1:0]), 2);
        chk("t6_pre_busy", 32'(md_busy), 1);
        reset = 1'b1;
        model_reset();
        settle_check();
        chk("t6_rst_stall", 32'(stall), 0);
        chk("t6_rst_busy", 32'(md_busy), 0);
        chk("t6_rst_sel_d", 32'(fwd_sel_d), 0);
        chk("t6_rst_sel_e", 32'(fwd_sel_e), 0);
        advance();
        reset = 1'b0;
        drain(2);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (reset) model_reset();
            src_addr_d = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            src_use_d  = NSRC'($urandom_range(0, 3));
            tuse_d     = {TW'($urandom_range(0, 1)), TW'($urandom_range(0, 1))};
            dst_we_d   = 1'($urandom_range(0, 1));
            dst_addr_d = AW'($urandom_range(0, 7));
            tnew_d     = TW'($urandom_range(0, 3));
            md_start_d = ($urandom_range(0, 19) == 0);
            md_div_d   = 1'($urandom_range(0, 1));
            md_use_d   = md_start_d | ($urandom_range(0, 5) == 0);
            flush_e    = ($urandom_range(0, 7) == 0);
            settle_check();
            advance();
        end
        reset = 1'b0;
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
